banner_scroller: RTL

Scrolling column fetcher for the banner graphic. Sits directly downstream of the banner ROM: it generates ROM column addresses, absorbs the ROM's one-cycle registered-address latency, and streams a `DISP_COLS`-wide window of 57-bit columns to the LED matrix driver over a valid/ready handshake. A programmable tick advances the window one column at a time, wrapping around the banner.

---
 rtl/banner_scroller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/banner_scroller.sv
// Scrolling column fetcher: walks a DISP_COLS-wide window over the banner ROM,
// hides the ROM's one-cycle address latency and streams columns over valid/ready.
module banner_scroller #(
    parameter int BANNER_LEN = 129,
    parameter int DISP_COLS  = 32,
    parameter int ROW_BITS   = 57,
    parameter int SCROLL_DIV = 1_000_000,
    localparam int IDX_W     = (DISP_COLS > 1) ? $clog2(DISP_COLS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic [7:0]          rom_addr,
    input  logic [ROW_BITS-1:0] rom_data,
    output logic [ROW_BITS-1:0] col_data,
    output logic [IDX_W-1:0]    col_idx,
    output logic                col_valid,
    input  logic                col_ready,
    output logic                frame_done,
    output logic [7:0]          scroll_pos
);

    localparam int TICK_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_DIV - 1);
    localparam logic [IDX_W-1:0]  COL_LAST  = IDX_W'(DISP_COLS - 1);
    localparam logic [8:0]        LEN_9     = 9'(BANNER_LEN);
    localparam logic [7:0]        POS_LAST  = 8'(BANNER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    col_q, col_d;
    logic [7:0]          rom_addr_q, rom_addr_d;
    logic [ROW_BITS-1:0] col_data_q, col_data_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic                col_valid_q, col_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          scroll_pos_q, scroll_pos_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                step_pending_q, step_pending_d;
    logic                tick_wrap;
    logic [8:0]          addr_sum;

    // Free-running tick divider; only runs while enabled.
    always_comb begin
        tick_d    = tick_q;
        tick_wrap = 1'b0;
        if (!enable) begin
            tick_d = '0;
        end else if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            tick_wrap = 1'b1;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        rom_addr_d     = rom_addr_q;
        col_data_d     = col_data_q;
        col_idx_d      = col_idx_q;
        col_valid_d    = col_valid_q;
        frame_done_d   = 1'b0;
        scroll_pos_d   = scroll_pos_q;
        step_pending_d = step_pending_q;
        addr_sum       = {1'b0, scroll_pos_q} + 9'(col_q);

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    col_d = '0;
                    if (step_pending_q) begin
                        scroll_pos_d   = (scroll_pos_q == POS_LAST) ? 8'd0 : scroll_pos_q + 8'd1;
                        step_pending_d = 1'b0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rom_addr_d = (addr_sum >= LEN_9) ? 8'(addr_sum - LEN_9) : addr_sum[7:0];
                state_d    = WAIT;
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                col_data_d  = rom_data;
                col_idx_d   = col_q;
                col_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (col_valid_q && col_ready) begin
                    col_valid_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick landing on the cycle a step is applied re-arms the request.
        if (tick_wrap) begin
            step_pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            rom_addr_q     <= '0;
            col_data_q     <= '0;
            col_idx_q      <= '0;
            col_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            scroll_pos_q   <= '0;
            tick_q         <= '0;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            rom_addr_q     <= rom_addr_d;
            col_data_q     <= col_data_d;
            col_idx_q      <= col_idx_d;
            col_valid_q    <= col_valid_d;
            frame_done_q   <= frame_done_d;
            scroll_pos_q   <= scroll_pos_d;
            tick_q         <= tick_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign col_data   = col_data_q;
    assign col_idx    = col_idx_q;
    assign col_valid  = col_valid_q;
    assign frame_done = frame_done_q;
    assign scroll_pos = scroll_pos_q;

endmodule
